acc_sweep_sequencer: RTL and testbench

- Controller placed in front of the accumulator IP, between the correlator AXIS output and the accumulator AXIS input.
- Per acquisition it zeroes the accumulator scratchpad BRAM, then aligns to a frame boundary.
- It then gates exactly accumulate_count frames of frame_len beats into the accumulator, and reports done or errors to the host.

---
 rtl/acc_sweep_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_acc_sweep_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sweep_sequencer.sv
// acc_sweep_sequencer
//
// Sequencer between the correlator AXIS output and the accumulator AXIS input.
// For each acquisition it:
//   1. zeroes every word of the accumulator scratchpad BRAM (CLEAR),
//   2. discards correlator beats up to and including the next tlast (SYNC),
//   3. passes exactly accumulate_count frames through to the accumulator (RUN),
//   4. pulses done for one cycle (DONE) and returns to IDLE.
// The abort input cancels any acquisition in progress.
//
// Ports
//   s00_axis_aclk       clock for all logic
//   s00_axis_areset     synchronous reset, active-high
//   start / abort       single-cycle control pulses from the host
//   accumulate_count    frames per acquisition, latched on start
//   frame_len           beats per frame (1..2^BRAM_DEPTH), latched on start
//   s00_axis_*          upstream correlator stream
//   m00_axis_*          downstream accumulator stream
//   clr_bram_*          scratchpad clear write port (data is always zero)
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   frame_cnt           frames completed in the current or last run
//   len_err             sticky: a frame length did not match frame_len
//   cfg_err             sticky: a start request was rejected
module acc_sweep_sequencer #(
  parameter int unsigned BRAM_DEPTH          = 10,
  parameter int unsigned ACC_BRAM_DATA_WIDTH = 128,
  parameter int unsigned C_AXIS_TDATA_WIDTH  = 96
) (
  input  logic                           s00_axis_aclk,
  input  logic                           s00_axis_areset,

  input  logic                           start,
  input  logic                           abort,
  input  logic [15:0]                    accumulate_count,
  input  logic [BRAM_DEPTH:0]            frame_len,

  input  logic                           s00_axis_tvalid,
  output logic                           s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]  s00_axis_tdata,
  input  logic                           s00_axis_tlast,

  output logic                           m00_axis_tvalid,
  input  logic                           m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]  m00_axis_tdata,
  output logic                           m00_axis_tlast,

  output logic [BRAM_DEPTH-1:0]          clr_bram_addr,
  output logic [ACC_BRAM_DATA_WIDTH-1:0] clr_bram_dataout,
  output logic                           clr_bram_we,

  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    frame_cnt,
  output logic                           len_err,
  output logic                           cfg_err
);

  // Width of frame_len / beat_cnt, and one extra bit for overflow-free compares.
  localparam int unsigned LenW  = BRAM_DEPTH + 1;
  localparam int unsigned LenWx = BRAM_DEPTH + 2;

  // Largest legal frame length: 2^BRAM_DEPTH.
  localparam logic [LenW-1:0] MaxLen = {1'b1, {BRAM_DEPTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSync,
    StRun,
    StDone
  } state_e;

  state_e                  state_q;
  logic [15:0]             acc_cnt_q;
  logic [LenW-1:0]         frame_len_q;
  logic [LenW-1:0]         beat_cnt_q;
  logic [15:0]             frame_cnt_q;
  logic [BRAM_DEPTH-1:0]   clr_addr_q;
  logic                    len_err_q;
  logic                    cfg_err_q;

  logic                    in_run;
  logic                    in_sync;
  logic                    beat_hs;
  logic                    sync_hs;
  logic                    cfg_bad;
  logic                    last_frame;
  logic [LenWx-1:0]        beat_num;
  logic [LenWx-1:0]        len_ext;
  logic [15:0]             frame_cnt_inc;

  // ---------------------------------------------------------------------------
  // Stream gating: zero-latency pass-through in RUN, drain-only in SYNC,
  // upstream held off everywhere else.
  // ---------------------------------------------------------------------------
  assign in_run          = (state_q == StRun);
  assign in_sync         = (state_q == StSync);

  assign m00_axis_tvalid = in_run & s00_axis_tvalid;
  assign s00_axis_tready = in_sync | (in_run & m00_axis_tready);
  assign m00_axis_tdata  = s00_axis_tdata;
  assign m00_axis_tlast  = s00_axis_tlast;

  assign beat_hs         = m00_axis_tvalid & m00_axis_tready;
  assign sync_hs         = in_sync & s00_axis_tvalid;

  // ---------------------------------------------------------------------------
  // Counter arithmetic
  // ---------------------------------------------------------------------------
  // 1-based index of the beat currently handshaking within its frame.
  assign beat_num      = {1'b0, beat_cnt_q} + LenWx'(1);
  assign len_ext       = {1'b0, frame_len_q};
  assign frame_cnt_inc = frame_cnt_q + 16'd1;
  assign last_frame    = (frame_cnt_inc == acc_cnt_q);

  assign cfg_bad = (accumulate_count == 16'd0) ||
                   (frame_len == '0) ||
                   (frame_len > MaxLen);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q     <= StIdle;
      acc_cnt_q   <= 16'd0;
      frame_len_q <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= 16'd0;
      clr_addr_q  <= '0;
      len_err_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Abort in the same cycle as start cancels the request outright.
          if (start && !abort) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              acc_cnt_q   <= accumulate_count;
              frame_len_q <= frame_len;
              beat_cnt_q  <= '0;
              frame_cnt_q <= 16'd0;
              clr_addr_q  <= '0;
              len_err_q   <= 1'b0;
              cfg_err_q   <= 1'b0;
              state_q     <= StClear;
            end
          end
        end

        StClear: begin
          // Address wraps back to zero after the last word, ready for next time.
          clr_addr_q <= clr_addr_q + BRAM_DEPTH'(1);
          if (clr_addr_q == '1) begin
            state_q <= StSync;
          end
        end

        StSync: begin
          // Everything up to and including the first tlast is a partial frame.
          if (sync_hs && s00_axis_tlast) begin
            state_q <= StRun;
          end
        end

        StRun: begin
          if (beat_hs) begin
            if (s00_axis_tlast) begin
              if (beat_num != len_ext) begin
                len_err_q <= 1'b1;
              end
              beat_cnt_q  <= '0;
              frame_cnt_q <= frame_cnt_inc;
              if (last_frame) begin
                state_q <= StDone;
              end
            end else begin
              // Overlong frame: flag on beat frame_len+1, keep counting to tlast.
              if (beat_num == len_ext + LenWx'(1)) begin
                len_err_q <= 1'b1;
              end
              if (beat_cnt_q != '1) begin
                beat_cnt_q <= beat_cnt_q + LenW'(1);
              end
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase

      // Abort overrides any transition, including RUN -> DONE. A beat that
      // handshakes in the abort cycle has already been counted above.
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state
  // ---------------------------------------------------------------------------
  // The reset term keeps the reset cycle itself from writing the scratchpad.
  assign clr_bram_we      = (state_q == StClear) & ~s00_axis_areset;
  assign clr_bram_addr    = clr_addr_q;
  assign clr_bram_dataout = '0;

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign frame_cnt = frame_cnt_q;
  assign len_err   = len_err_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_acc_sweep_sequencer.sv
// Self-checking bench for acc_sweep_sequencer (BRAM_DEPTH = 4).
// Forwarded beats are pushed to a scoreboard queue when driven and popped when
// they appear on the downstream handshake.
module tb_acc_sweep_sequencer;

  localparam int unsigned Depth = 4;
  localparam int unsigned DataW = 96;
  localparam int unsigned BramW = 128;

  logic              clk = 1'b0;
  logic              areset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       accumulate_count = 16'd0;
  logic [Depth:0]    frame_len = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DataW-1:0]  s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [DataW-1:0]  m_tdata;
  logic              m_tlast;
  logic [Depth-1:0]  clr_addr;
  logic [BramW-1:0]  clr_data;
  logic              clr_we;
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;
  logic              len_err;
  logic              cfg_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DataW:0] exp_q[$];
  logic [DataW:0] mon_got;
  logic [DataW:0] mon_exp;
  logic [Depth-1:0] addr_exp;

  int  we_total = 0;
  int  hs_total = 0;
  int  done_total = 0;
  int  we_base = 0;
  int  hs_base = 0;
  int  done_base = 0;
  bit  rand_rdy = 1'b0;

  always #5 clk = ~clk;

  acc_sweep_sequencer #(
    .BRAM_DEPTH          (Depth),
    .ACC_BRAM_DATA_WIDTH (BramW),
    .C_AXIS_TDATA_WIDTH  (DataW)
  ) u_dut (
    .s00_axis_aclk    (clk),
    .s00_axis_areset  (areset),
    .start            (start),
    .abort            (abort),
    .accumulate_count (accumulate_count),
    .frame_len        (frame_len),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tlast   (s_tlast),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tlast   (m_tlast),
    .clr_bram_addr    (clr_addr),
    .clr_bram_dataout (clr_data),
    .clr_bram_we      (clr_we),
    .busy             (busy),
    .done             (done),
    .frame_cnt        (frame_cnt),
    .len_err          (len_err),
    .cfg_err          (cfg_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: always 1, or a fresh coin flip every cycle.
  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr_we) begin
      addr_exp = 4'(we_total - we_base);
      check("clr_addr", {124'd0, clr_addr}, {124'd0, addr_exp});
      check("clr_data", clr_data, 128'd0);
      check("clr_hold", {127'd0, s_tready}, 128'd0);
      we_total++;
    end
    if (m_tvalid) begin
      check("rdy_follow", {127'd0, s_tready}, {127'd0, m_tready});
    end
    if (m_tvalid && m_tready) begin
      mon_got = {m_tlast, m_tdata};
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~mon_got;
      check("fwd_beat", {31'd0, mon_got}, {31'd0, mon_exp});
      hs_total++;
    end
    if (done) begin
      done_total++;
    end
  end

  task automatic send_beat(input logic last, input bit fwd);
    logic [DataW-1:0] d;
    d = {$urandom(), $urandom(), $urandom()};
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    if (fwd) exp_q.push_back({last, d});
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (s_tready) break;
      if (i >= 300) begin
        check("tready_timeout", {127'd0, s_tready}, 128'd1);
        break;
      end
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int beats);
    for (int b = 0; b < beats; b++) begin
      send_beat(b == beats - 1, 1'b1);
    end
  endtask

  task automatic pulse_start(input logic [15:0] acc, input logic [Depth:0] len);
    accumulate_count = acc;
    frame_len        = len;
    start            = 1'b1;
    we_base          = we_total;
    hs_base          = hs_total;
    done_base        = done_total;
    tick();
    start = 1'b0;
  endtask

  // Called right after the final tlast handshake: done must be up next cycle.
  task automatic expect_done(input string tag, input int hs_exp);
    @(negedge clk);
    check({tag, "_done"}, {127'd0, done}, 128'd1);
    check({tag, "_hs"}, 128'(hs_total - hs_base), 128'(hs_exp));
    @(negedge clk);
    check({tag, "_done_1cyc"}, {127'd0, done}, 128'd0);
    check({tag, "_idle"}, {127'd0, busy}, 128'd0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  {127'd0, busy},     128'd0);
    check({tag, "_done"},  {127'd0, done},     128'd0);
    check({tag, "_fcnt"},  {112'd0, frame_cnt}, 128'd0);
    check({tag, "_lerr"},  {127'd0, len_err},  128'd0);
    check({tag, "_cerr"},  {127'd0, cfg_err},  128'd0);
    check({tag, "_we"},    {127'd0, clr_we},   128'd0);
    check({tag, "_addr"},  {124'd0, clr_addr}, 128'd0);
    check({tag, "_srdy"},  {127'd0, s_tready}, 128'd0);
    check({tag, "_mval"},  {127'd0, m_tvalid}, 128'd0);
  endtask

  initial begin
    repeat (3) tick();
    areset = 1'b0;
    check_reset_vals("rst");

    // Nominal run: 2 partial beats + tlast are dropped, then 3 x 16 forwarded.
    pulse_start(16'd3, 5'd16);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(16);
    expect_done("t1", 48);
    check("t1_fcnt", {112'd0, frame_cnt}, 128'd3);
    check("t1_lerr", {127'd0, len_err}, 128'd0);
    check("t1_clears", 128'(we_total - we_base), 128'd16);
    check("t1_sb_empty", 128'(exp_q.size()), 128'd0);

    // Random downstream backpressure.
    rand_rdy = 1'b1;
    pulse_start(16'd3, 5'd16);
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(16);
    expect_done("t2", 48);
    check("t2_fcnt", {112'd0, frame_cnt}, 128'd3);
    check("t2_sb_empty", 128'(exp_q.size()), 128'd0);
    rand_rdy = 1'b0;
    tick();

    // Short second frame sets len_err; run still completes.
    pulse_start(16'd3, 5'd16);
    send_beat(1'b1, 1'b0);
    send_frame(16);
    check("t3_lerr_f1", {127'd0, len_err}, 128'd0);
    send_frame(15);
    check("t3_lerr_f2", {127'd0, len_err}, 128'd1);
    send_frame(16);
    expect_done("t3", 47);
    check("t3_fcnt", {112'd0, frame_cnt}, 128'd3);
    check("t3_lerr_end", {127'd0, len_err}, 128'd1);

    // Rejected start: zero accumulate_count.
    pulse_start(16'd0, 5'd16);
    check("t4_cerr", {127'd0, cfg_err}, 128'd1);
    check("t4_busy", {127'd0, busy}, 128'd0);
    repeat (5) tick();
    check("t4_no_clear", 128'(we_total - we_base), 128'd0);

    // Abort during frame 2.
    pulse_start(16'd3, 5'd16);
    check("t5_cerr_clr", {127'd0, cfg_err}, 128'd0);
    send_beat(1'b1, 1'b0);
    send_frame(16);
    for (int b = 0; b < 5; b++) send_beat(1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", {127'd0, busy}, 128'd0);
    check("t5_srdy", {127'd0, s_tready}, 128'd0);
    check("t5_fcnt", {112'd0, frame_cnt}, 128'd1);
    repeat (4) tick();
    check("t5_no_done", 128'(done_total - done_base), 128'd0);
    check("t5_sb_empty", 128'(exp_q.size()), 128'd0);

    // Restart does the full clear; a start during CLEAR is ignored.
    pulse_start(16'd3, 5'd16);
    repeat (5) tick();
    accumulate_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("t6_clears", 128'(we_total - we_base), 128'd16);
    check("t6_cerr", {127'd0, cfg_err}, 128'd0);
    check("t6_busy", {127'd0, busy}, 128'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_idle", {127'd0, busy}, 128'd0);

    // frame_len one past the maximum is rejected.
    pulse_start(16'd3, 5'd17);
    check("t7_cerr", {127'd0, cfg_err}, 128'd1);
    check("t7_busy", {127'd0, busy}, 128'd0);
    repeat (3) tick();
    check("t7_no_clear", 128'(we_total - we_base), 128'd0);

    // Reset at clear address 7.
    pulse_start(16'd3, 5'd16);
    for (int i = 0; ; i++) begin
      if (clr_addr == 4'd7) break;
      if (i >= 40) begin
        check("t8_addr7_timeout", {124'd0, clr_addr}, 128'd7);
        break;
      end
      tick();
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_reset_vals("t8");
    check("t8_clears", 128'(we_total - we_base), 128'd7);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
